instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
Instruction fetch stage between the instruction SRAM (synchronous read, 1-cycle latency) and the core's decode stage. It owns the fetch PC and issues word-addressed reads. Returned words go into a small prefetch FIFO. Instructions are presented to decode with a valid/ready handshake. It supports redirect (branch/jump) with flush of buffered and in-flight fetches.

Parameters:
INSTR_WIDTH, 32, instruction word width
ADDR_WIDTH, 8, instruction memory word-address width
RESET_PC, 0, fetch PC after reset (word address)
FIFO_DEPTH, 2, prefetch buffer entries (power of 2, >=2)

Ports:
i_clk  input  1  clock, all state on rising edge
i_rst  input  1  asynchronous reset, active-high
o_mem_addr  output  ADDR_WIDTH  SRAM read address
o_mem_req  output  1  read issued this cycle
o_mem_we  output  1  instruction bus write enable, constant 0
i_mem_rdata  input  INSTR_WIDTH  SRAM read data, valid the cycle after o_mem_req
o_instr  output  INSTR_WIDTH  FIFO head instruction
o_pc  output  ADDR_WIDTH  word address of o_instr
o_valid  output  1  o_instr/o_pc valid
i_ready  input  1  decode accepts head when o_valid&i_ready (pop)
i_redirect  input  1  flush and restart fetch
i_redirect_pc  input  ADDR_WIDTH  new fetch address, sampled with i_redirect

Behaviour:
- Reset (async, i_rst=1): fetch_pc=RESET_PC, FIFO empty, inflight=0, state=BOOT, o_valid=0, o_mem_req=0, o_instr=0, o_pc=0. o_mem_addr follows fetch_pc combinationally. Reset mid-fetch discards everything; the returning SRAM word is ignored.
- FSM:
  - BOOT: one cycle with no request, then RUN.
  - RUN: normal fetch.
  - There is no other state.
- Request rule (RUN, combinational): o_mem_req = !i_redirect && (count + inflight - pop) < FIFO_DEPTH.
  - pop = o_valid & i_ready in the same cycle.
  - This sustains 1 instr/cycle with i_ready held high.
- o_mem_addr = fetch_pc at all times.
- On request: fetch_pc <= fetch_pc+1, wrapping modulo 2^ADDR_WIDTH (0xFF -> 0x00 for ADDR_WIDTH=8). Also inflight <= 1 and inflight_pc <= fetch_pc.
- Next cycle, if inflight and not killed: push {i_mem_rdata, inflight_pc} to FIFO tail. inflight clears unless a new request is issued.
- Same-cycle push and pop are allowed: count is unchanged and order is preserved. The FIFO can never overflow, because the request rule reserves space. Pop when empty is impossible (o_valid=0).
- o_valid = (count != 0). o_instr/o_pc = head entry, registered and stable while o_valid && !i_ready.
- Redirect (i_redirect=1, priority over push/pop/request):
  - FIFO is cleared.
  - Any in-flight read is killed; its data next cycle is dropped.
  - fetch_pc <= i_redirect_pc.
  - o_mem_req=0 that cycle.
  - Next cycle: o_valid=0 and the request for i_redirect_pc is issued.
  - o_valid=1 with o_pc=i_redirect_pc two cycles after the redirect cycle.
  - Back-to-back redirects: the last one wins. Redirect during BOOT is honored and the state moves to RUN.
- Latency from RESET deassert: BOOT cycle, request cycle, then o_valid=1 on the following cycle (3rd edge after release).

Optional Feature:
FETCH_PERF_EN: adds outputs o_fetch_cnt[31:0] and o_stall_cnt[31:0].
- o_fetch_cnt: instructions popped.
- o_stall_cnt: cycles with o_valid && !i_ready.
- Both reset to 0 and wrap at 2^32. Redirect does not clear them.
- Without the macro these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset release, mem[n]=n+0x100, i_ready=1 -> o_valid first high 3 edges after release with o_pc=0, o_instr=0x100; then o_pc 1,2,3... every cycle with no bubbles.
- i_ready=0 for 5 cycles after first valid -> o_mem_req drops once count+inflight=2; o_instr holds 0x100; on ready, o_pc 0,1,2 appear consecutively without gaps.
- i_redirect=1, i_redirect_pc=0x40 while FIFO full and read in flight -> next cycle o_valid=0, o_mem_addr=0x40; o_pc=0x40 two cycles after redirect; stale words never appear.
- Start fetch at redirect pc 0xFE, ready=1 -> o_pc sequence 0xFE, 0xFF, 0x00, 0x01.
- Assert i_rst asynchronously mid-stream (between edges) -> o_valid and o_mem_req fall immediately; after release, fetch restarts at RESET_PC with BOOT cycle.
- FETCH_PERF_EN: 10 pops with 3 stall cycles -> o_fetch_cnt=10, o_stall_cnt=3; a redirect leaves both unchanged.

Source files
------------

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// instr_fetch_unit: owns the fetch PC, issues 1-cycle SRAM reads, buffers words in a prefetch FIFO for decode.
// Optional macro FETCH_PERF_EN adds o_fetch_cnt / o_stall_cnt performance counters.  Rev 1.0
module instr_fetch_unit #(
   parameter int INSTR_WIDTH = 32,
   parameter int ADDR_WIDTH  = 8,
   parameter int RESET_PC    = 0,
   parameter int FIFO_DEPTH  = 2
) (
   input  logic                   i_clk,
   input  logic                   i_rst,
   output logic [ADDR_WIDTH-1:0]  o_mem_addr,
   output logic                   o_mem_req,
   output logic                   o_mem_we,
   input  logic [INSTR_WIDTH-1:0] i_mem_rdata,
   output logic [INSTR_WIDTH-1:0] o_instr,
   output logic [ADDR_WIDTH-1:0]  o_pc,
   output logic                   o_valid,
   input  logic                   i_ready,
   input  logic                   i_redirect,
   input  logic [ADDR_WIDTH-1:0]  i_redirect_pc
`ifdef FETCH_PERF_EN
   ,
   output logic [31:0]            o_fetch_cnt,
   output logic [31:0]            o_stall_cnt
`endif
);

   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W:0]        DEPTH_C = (CNT_W + 1)'(FIFO_DEPTH);
   localparam logic [ADDR_WIDTH-1:0] PC_RST  = ADDR_WIDTH'(RESET_PC);

   typedef enum logic [0:0] {
      BOOT = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t                  state;
   state_t                  state_nxt;

   logic [ADDR_WIDTH-1:0]   fetch_pc;
   logic [ADDR_WIDTH-1:0]   inflight_pc;
   logic                    inflight;

   logic [INSTR_WIDTH-1:0]  buf_instr [FIFO_DEPTH];
   logic [ADDR_WIDTH-1:0]   buf_pc    [FIFO_DEPTH];
   logic [PTR_W-1:0]        wr_ptr;
   logic [PTR_W-1:0]        rd_ptr;
   logic [CNT_W-1:0]        count;

   logic                    req;
   logic                    pop;
   logic                    push;
   logic [CNT_W:0]          occupancy;

   assign o_valid    = (count != '0);
   assign o_instr    = buf_instr[rd_ptr];
   assign o_pc       = buf_pc[rd_ptr];
   assign o_mem_addr = fetch_pc;
   assign o_mem_we   = 1'b0;
   assign o_mem_req  = req;

   assign pop  = o_valid & i_ready;
   // A redirect kills the word returning this cycle.
   assign push = inflight & ~i_redirect;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state <= BOOT;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      req       = 1'b0;
      // Space already promised to buffered and returning words, less the one leaving now.
      occupancy = {1'b0, count} + (CNT_W + 1)'(inflight) - (CNT_W + 1)'(pop);
      case (state)
         BOOT: begin
            state_nxt = RUN;
         end
         RUN: begin
            req = ~i_redirect && (occupancy < DEPTH_C);
         end
         default: begin
            state_nxt = BOOT;
         end
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         fetch_pc    <= PC_RST;
         inflight    <= 1'b0;
         inflight_pc <= '0;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         count       <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            buf_instr[i] <= '0;
            buf_pc[i]    <= '0;
         end
      end else if (i_redirect) begin
         fetch_pc <= i_redirect_pc;
         inflight <= 1'b0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
      end else begin
         inflight <= req;
         if (req) begin
            fetch_pc    <= fetch_pc + ADDR_WIDTH'(1);
            inflight_pc <= fetch_pc;
         end
         if (push) begin
            buf_instr[wr_ptr] <= i_mem_rdata;
            buf_pc[wr_ptr]    <= inflight_pc;
            wr_ptr            <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

`ifdef FETCH_PERF_EN
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         o_fetch_cnt <= '0;
         o_stall_cnt <= '0;
      end else begin
         if (pop) begin
            o_fetch_cnt <= o_fetch_cnt + 32'd1;
         end
         if (o_valid && !i_ready) begin
            o_stall_cnt <= o_stall_cnt + 32'd1;
         end
      end
   end
`endif

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// Testbench for instr_fetch_unit: stream-level model plus directed latency/stall/redirect/wrap/reset vectors.
module tb_instr_fetch_unit;

   localparam int IW    = 32;
   localparam int AW    = 8;
   localparam int DEPTH = 2;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [AW-1:0] mem_addr;
   logic          mem_req;
   logic          mem_we;
   logic [IW-1:0] mem_rdata = '0;
   logic [IW-1:0] instr;
   logic [AW-1:0] pc;
   logic          valid;
   logic          ready = 1'b1;
   logic          redirect = 1'b0;
   logic [AW-1:0] redirect_pc = '0;
`ifdef FETCH_PERF_EN
   logic [31:0]   fetch_cnt;
   logic [31:0]   stall_cnt;
`endif

   int checks   = 0;
   int failures = 0;

   instr_fetch_unit #(
      .INSTR_WIDTH(IW), .ADDR_WIDTH(AW), .RESET_PC(0), .FIFO_DEPTH(DEPTH)
   ) dut (
      .i_clk(clk), .i_rst(rst),
      .o_mem_addr(mem_addr), .o_mem_req(mem_req), .o_mem_we(mem_we),
      .i_mem_rdata(mem_rdata),
      .o_instr(instr), .o_pc(pc), .o_valid(valid), .i_ready(ready),
      .i_redirect(redirect), .i_redirect_pc(redirect_pc)
`ifdef FETCH_PERF_EN
      , .o_fetch_cnt(fetch_cnt), .o_stall_cnt(stall_cnt)
`endif
   );

   always #5 clk = ~clk;

   function automatic logic [IW-1:0] memf(input logic [AW-1:0] a);
      return 32'h100 + {24'h0, a};
   endfunction

   // SRAM: data only for real requests, garbage otherwise so mistimed captures show up.
   always @(posedge clk) begin
      mem_rdata <= mem_req ? memf(mem_addr) : 32'hDEAD_BEEF;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Stream model: decode must see consecutive addresses from the last restart point,
   // requests must walk the same address sequence, and unconsumed fetches never exceed DEPTH.
   logic [AW-1:0] exp_head;
   logic [AW-1:0] exp_req;
   int            outstanding;
`ifdef FETCH_PERF_EN
   logic [31:0]   m_pops;
   logic [31:0]   m_stalls;
`endif

   always @(negedge clk) begin
      if (rst) begin
         exp_head    = 8'h00;
         exp_req     = 8'h00;
         outstanding = 0;
`ifdef FETCH_PERF_EN
         m_pops   = 0;
         m_stalls = 0;
`endif
      end else begin
         chk("mem_we", {31'b0, mem_we}, 32'd0);
         if (valid) begin
            chk("model_pc", {24'h0, pc}, {24'h0, exp_head});
            chk("model_instr", instr, memf(exp_head));
            chk("model_valid_backed", {31'b0, outstanding >= 1}, 32'd1);
         end
         if (mem_req) chk("model_req_addr", {24'h0, mem_addr}, {24'h0, exp_req});
         if (redirect) chk("model_req_in_redirect", {31'b0, mem_req}, 32'd0);
`ifdef FETCH_PERF_EN
         chk("model_fetch_cnt", fetch_cnt, m_pops);
         chk("model_stall_cnt", stall_cnt, m_stalls);
         if (valid && ready) m_pops++;
         if (valid && !ready) m_stalls++;
`endif
         if (redirect) begin
            exp_head    = redirect_pc;
            exp_req     = redirect_pc;
            outstanding = 0;
         end else begin
            if (valid && ready) begin
               exp_head++;
               outstanding--;
            end
            if (mem_req) begin
               exp_req++;
               outstanding++;
            end
         end
         chk("model_outstanding", {31'b0, outstanding <= DEPTH}, 32'd1);
      end
   end

   initial begin
      // Reset release, ready high: first valid on the 3rd edge, then back-to-back.
      repeat (2) step();
      rst = 1'b0;
      chk("boot_no_req", {31'b0, mem_req}, 32'd0);
      chk("reset_valid", {31'b0, valid}, 32'd0);
      chk("reset_instr", instr, 32'd0);
      chk("reset_pc", {24'h0, pc}, 32'd0);
      chk("reset_addr", {24'h0, mem_addr}, 32'd0);
      step();
      chk("edge1_valid", {31'b0, valid}, 32'd0);
      chk("edge1_req", {31'b0, mem_req}, 32'd1);
      step();
      chk("edge2_valid", {31'b0, valid}, 32'd0);
      step();
      chk("first_valid", {31'b0, valid}, 32'd1);
      chk("first_pc", {24'h0, pc}, 32'h0);
      chk("first_instr", instr, 32'h100);
      for (int k = 1; k <= 5; k++) begin
         step();
         chk("stream_valid", {31'b0, valid}, 32'd1);
         chk("stream_pc", {24'h0, pc}, k);
         chk("stream_instr", instr, 32'h100 + k);
      end

      // Stall: decode not ready for 5 cycles after first valid.
      rst = 1'b1;
      repeat (2) step();
      ready = 1'b0;
      rst   = 1'b0;
      repeat (3) step();
      for (int k = 0; k < 5; k++) begin
         chk("stall_valid", {31'b0, valid}, 32'd1);
         chk("stall_pc", {24'h0, pc}, 32'h0);
         chk("stall_instr", instr, 32'h100);
         chk("stall_no_req", {31'b0, mem_req}, 32'd0);
         if (k < 4) step();
      end
      ready = 1'b1;
      #1;
      chk("unstall_req", {31'b0, mem_req}, 32'd1);
      for (int k = 1; k <= 3; k++) begin
         step();
         chk("unstall_valid", {31'b0, valid}, 32'd1);
         chk("unstall_pc", {24'h0, pc}, k);
      end

      // Redirect mid-stream with a read in flight.
      redirect    = 1'b1;
      redirect_pc = 8'h40;
      #1;
      chk("redir_no_req", {31'b0, mem_req}, 32'd0);
      step();
      redirect = 1'b0;
      chk("redir_n1_valid", {31'b0, valid}, 32'd0);
      #1;
      chk("redir_n1_addr", {24'h0, mem_addr}, 32'h40);
      chk("redir_n1_req", {31'b0, mem_req}, 32'd1);
      step();
      chk("redir_n2_valid", {31'b0, valid}, 32'd0);
      step();
      chk("redir_valid", {31'b0, valid}, 32'd1);
      chk("redir_pc", {24'h0, pc}, 32'h40);
      chk("redir_instr", instr, 32'h140);
      step();
      chk("redir_next_pc", {24'h0, pc}, 32'h41);

      // Back-to-back redirects (last wins), then wrap past 0xFF.
      redirect    = 1'b1;
      redirect_pc = 8'h10;
      step();
      redirect_pc = 8'hFE;
      step();
      redirect = 1'b0;
      chk("b2b_valid0", {31'b0, valid}, 32'd0);
      step();
      chk("b2b_valid1", {31'b0, valid}, 32'd0);
      step();
      chk("wrap_pc_fe", {24'h0, pc}, 32'hFE);
      step();
      chk("wrap_pc_ff", {24'h0, pc}, 32'hFF);
      step();
      chk("wrap_pc_00", {24'h0, pc}, 32'h00);
      chk("wrap_instr_00", instr, 32'h100);
      step();
      chk("wrap_pc_01", {24'h0, pc}, 32'h01);

      // Asynchronous reset between edges, then restart from RESET_PC through BOOT.
      @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      chk("async_valid", {31'b0, valid}, 32'd0);
      chk("async_req", {31'b0, mem_req}, 32'd0);
      chk("async_addr", {24'h0, mem_addr}, 32'h0);
      repeat (2) step();
      rst = 1'b0;
      repeat (2) step();
      chk("restart_e2_valid", {31'b0, valid}, 32'd0);
      step();
      chk("restart_valid", {31'b0, valid}, 32'd1);
      chk("restart_pc", {24'h0, pc}, 32'h0);

      // Redirect during BOOT.
      rst = 1'b1;
      repeat (2) step();
      rst         = 1'b0;
      redirect    = 1'b1;
      redirect_pc = 8'h80;
      #1;
      chk("boot_redir_no_req", {31'b0, mem_req}, 32'd0);
      step();
      redirect = 1'b0;
      #1;
      chk("boot_redir_addr", {24'h0, mem_addr}, 32'h80);
      chk("boot_redir_req", {31'b0, mem_req}, 32'd1);
      repeat (2) step();
      chk("boot_redir_valid", {31'b0, valid}, 32'd1);
      chk("boot_redir_pc", {24'h0, pc}, 32'h80);
      chk("boot_redir_instr", instr, 32'h180);

      // Mixed ready pattern for the stream model.
      for (int k = 0; k < 13; k++) begin
         ready = (k % 4 != 1);
         step();
      end
`ifdef FETCH_PERF_EN
      ready = 1'b1;
      step();
      chk("perf_fetch", fetch_cnt, m_pops);
      redirect    = 1'b1;
      redirect_pc = 8'h20;
      ready       = 1'b0;
      step();
      redirect = 1'b0;
      chk("perf_stall_kept", stall_cnt, m_stalls);
`endif
      ready = 1'b1;
      repeat (3) step();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
